// File: rtl/minitest_shr_pkg.sv
// minitest_shr_pkg
//   Shared definitions for the minitest shift-register host slice:
//   FSM state encoding, default chain lengths and the counter-width helper.
package minitest_shr_pkg;

  localparam int DIN_N_DEF  = 160;
  localparam int DOUT_N_DEF = 160;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT1,
    APPLY,
    SHIFT2,
    CAPTURE,
    DRAIN,
    DONE
  } state_t;

  // Width of a counter that must reach max(a, b).
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/minitest_shr_deser.sv
// minitest_shr_deser
//   Response deserialiser. While en is high it first discards DO_LAT bits
//   (pipeline latency on the DUT response path), then shifts sdi into data
//   MSB-first. data holds its value whenever en is low.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   en          high for every DRAIN cycle
//   sdi         serial response bit from the DUT (after any delay stages)
//   data        captured DOUT_N-bit response
import minitest_shr_pkg::*;

module minitest_shr_deser #(
  parameter int DOUT_N = DOUT_N_DEF,
  parameter int DO_LAT = 0,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              sdi,
  output logic [DOUT_N-1:0] data
);

  logic [CNT_W-1:0] skip;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skip <= '0;
      data <= '0;
    end else if (!en) begin
      skip <= '0;
    end else if (skip != CNT_W'(DO_LAT)) begin
      skip <= skip + 1'b1;
    end else begin
      data <= {data[DOUT_N-2:0], sdi};
    end
  end

endmodule

// File: rtl/minitest_shr_host.sv
// minitest_shr_host
//   Host for a serial-scan DUT: shifts a stimulus vector in twice around an
//   apply strobe, strobes a capture, then drains the DUT response chain.
//   Optional compare against an expected response when the macro
//   MINITEST_SHR_HOST_MISMATCH_EN is defined.
// Ports:
//   clk, rst_n                  clock (shared with DUT), async active-low reset
//   req_valid/req_ready/req_data   stimulus request handshake
//   rsp_valid/rsp_ready/rsp_data   response handshake
//   req_exp, rsp_mismatch       expected response / compare result (macro only)
//   di, stb                     serial stimulus and apply/capture strobe to DUT
//   dut_do                      serial response from DUT ("do" is a
//                               SystemVerilog keyword, hence this name)
import minitest_shr_pkg::*;

module minitest_shr_host #(
  parameter int DIN_N  = DIN_N_DEF,
  parameter int DOUT_N = DOUT_N_DEF,
  parameter int DO_LAT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DIN_N-1:0]  req_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DOUT_N-1:0] rsp_data,
`ifdef MINITEST_SHR_HOST_MISMATCH_EN
  input  logic [DOUT_N-1:0] req_exp,
  output logic              rsp_mismatch,
`endif
  output logic              di,
  output logic              stb,
  input  logic              dut_do
);

  localparam int unsigned CNT_W = cnt_width(DIN_N, DOUT_N + DO_LAT);
  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(DIN_N - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DO_LAT + DOUT_N - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [DIN_N-1:0] vec;

  // vec is rotated left once per shift cycle instead of being indexed by
  // cnt; after DIN_N rotations it is back to the latched value, so SHIFT2
  // re-sends the identical vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      vec   <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (req_valid) begin
            state <= SHIFT1;
            vec   <= req_data;
          end
        end
        SHIFT1, SHIFT2: begin
          vec <= {vec[DIN_N-2:0], vec[DIN_N-1]};
          if (cnt == SHIFT_LAST) begin
            state <= (state == SHIFT1) ? APPLY : CAPTURE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        APPLY: begin
          state <= SHIFT2;
          cnt   <= '0;
        end
        CAPTURE: begin
          state <= DRAIN;
          cnt   <= '0;
        end
        DRAIN: begin
          if (cnt == DRAIN_LAST) begin
            state <= DONE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          cnt <= '0;
          if (rsp_ready) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    di        = ((state == SHIFT1) || (state == SHIFT2)) ? vec[DIN_N-1] : 1'b0;
    stb       = (state == APPLY) || (state == CAPTURE);
    req_ready = (state == IDLE);
    rsp_valid = (state == DONE);
  end

  minitest_shr_deser #(
    .DOUT_N (DOUT_N),
    .DO_LAT (DO_LAT),
    .CNT_W  (CNT_W)
  ) u_deser (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state == DRAIN),
    .sdi   (dut_do),
    .data  (rsp_data)
  );

`ifdef MINITEST_SHR_HOST_MISMATCH_EN
  logic [DOUT_N-1:0] exp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q <= '0;
    end else if (state == IDLE && req_valid) begin
      exp_q <= req_exp;
    end
  end

  always_comb rsp_mismatch = (state == DONE) && (rsp_data != exp_q);
`endif

endmodule

// File: doc/minitest_shr_host.md
MINITEST_SHR_HOST -- requirements
Module: minitest_shr_host

Interface
REQ-001 Parameter DIN_N, default 160: stimulus vector width, the length of the DUT din shift chain.
REQ-002 Parameter DOUT_N, default 160: response vector width, the length of the DUT dout shift chain.
REQ-003 Parameter DO_LAT, default 0: number of extra register stages between DUT do and host do input.
REQ-004 Port list:
- clk, input, 1: single clock, shared with DUT.
- rst_n, input, 1: asynchronous active-low reset.
- req_valid, input, 1: request present.
- req_ready, output, 1: host idle, can accept a request.
- req_data, input, DIN_N: stimulus vector.
- rsp_valid, output, 1: response held.
- rsp_ready, input, 1: consumer accepts the response.
- rsp_data, output, DOUT_N: captured response vector.
- di, output, 1: serial stimulus to DUT.
- stb, output, 1: DUT apply/capture strobe.
- do, input, 1: serial response from DUT.

Function
REQ-005 FSM states SHALL be IDLE, SHIFT1, APPLY, SHIFT2, CAPTURE, DRAIN and DONE.
REQ-006 IDLE: req_ready=1; a request is accepted on a clock edge where req_valid=1, and the FSM goes to SHIFT1 with req_data latched.
REQ-007 SHIFT1 and SHIFT2 each last DIN_N cycles; in cycle k (0..DIN_N-1) di SHALL be vec[DIN_N-1-k], MSB first, and stb=0.
REQ-008 APPLY SHALL last 1 cycle with stb=1 and di=0, which loads DUT din with vec; the next state is SHIFT2.
REQ-009 SHIFT2 SHALL re-shift the same vec, so DUT din_shr equals vec at the CAPTURE edge.
REQ-010 CAPTURE SHALL last 1 cycle with stb=1 and di=0; this captures DUT dout and reloads the unchanged vec.
REQ-011 DRAIN SHALL last DO_LAT+DOUT_N cycles with stb=0 and di=0:
- The first DO_LAT cycles are discarded.
- In each remaining cycle, rsp_data <= {rsp_data[DOUT_N-2:0], do}.
- Result: rsp_data[DOUT_N-1] equals DUT dout[DOUT_N-1].
REQ-012 DONE: rsp_valid=1, rsp_data stable; on an edge with rsp_ready=1 the FSM goes to IDLE.
REQ-013 Latency: rsp_valid SHALL rise exactly 2*DIN_N+DOUT_N+DO_LAT+2 edges after the accepting edge (482 at defaults).
REQ-014 stb SHALL never be high in two consecutive cycles and SHALL be high only in APPLY and CAPTURE.
REQ-015 req_valid is ignored outside IDLE; req_data changes after acceptance SHALL NOT affect di.
REQ-016 rsp_ready while not in DONE is ignored.
REQ-017 Counters SHALL be sized $clog2(max(DIN_N, DOUT_N+DO_LAT)+1) and SHALL reset to 0 on every state entry.

Reset
REQ-018 rst_n low SHALL asynchronously force:
- state=IDLE, all counters 0
- di=0, stb=0
- req_ready=1, rsp_valid=0, rsp_data=0
REQ-019 Reset in any state mid-operation SHALL abandon the transaction without emitting stb, and the first accepted request after release SHALL behave as REQ-006..013.

Configuration
REQ-020 With macro MINITEST_SHR_HOST_MISMATCH_EN defined, the block SHALL add:
- input req_exp [DOUT_N]: expected response, latched with req_data.
- output rsp_mismatch [1]: (rsp_data != req_exp), valid with rsp_valid, reset 0.
REQ-021 Without the macro, neither port exists and no compare logic is built.

Structure
REQ-022 Package minitest_shr_pkg SHALL hold the state enum and the default DIN_N/DOUT_N constants (160).
REQ-023 Sub-module minitest_shr_deser SHALL hold the DO_LAT skip counter and the DOUT_N-bit capture shift register.

Verification
REQ-024 The bench SHALL model the DUT shift/strobe chain exactly, with roi: dout = din (identity).
REQ-025 Identity loopback: req_data=160'h1 -> rsp_data=160'h1, rsp_valid rises 482 edges after acceptance, stb high exactly twice.
REQ-026 Inverting roi with req_data=all-zero -> rsp_data=all-ones; with MISMATCH_EN and req_exp=0 -> rsp_mismatch=1.
REQ-027 DO_LAT=2 with 2 extra flops on do, req_data=160'hA5 (zero-extended) -> rsp_data=160'hA5, latency 484.
REQ-028 rst_n pulsed low during SHIFT2 cycle 50 -> di=0, stb=0 immediately; next request 160'h3 -> rsp_data=160'h3.
REQ-029 rsp_ready held 0 for 20 cycles in DONE -> rsp_valid and rsp_data stable, req_ready=0, a second req_valid is not accepted until after the rsp handshake.
